// File: rtl/decode_stage.sv
// Registered RV32I decode stage: decodes R/I ALU ops, LW, SW, BEQ/BNE and LUI,
// builds the sign-extended immediate, detects load-use hazards and drives a
// valid/ready output register towards EX.
module decode_stage #(
  parameter int unsigned XLEN          = 32,
  parameter bit          ENABLE_SHIFTS = 1'b1,
  parameter bit          HAZARD_DETECT = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic            flush,
  input  logic            ex_mem_read,
  input  logic [4:0]      ex_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic [3:0]      out_alu_op,
  output logic            out_alu_src,
  output logic            out_reg_write,
  output logic            out_mem_read,
  output logic            out_mem_write,
  output logic            out_mem_to_reg,
  output logic [1:0]      out_branch,
  output logic [2:0]      out_encoding,
  output logic            out_illegal
);

  localparam logic [6:0] OpcReg    = 7'b0110011;
  localparam logic [6:0] OpcImm    = 7'b0010011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcLui    = 7'b0110111;

  localparam logic [3:0] AluAdd   = 4'd0;
  localparam logic [3:0] AluSub   = 4'd1;
  localparam logic [3:0] AluSll   = 4'd2;
  localparam logic [3:0] AluSlt   = 4'd3;
  localparam logic [3:0] AluSltu  = 4'd4;
  localparam logic [3:0] AluXor   = 4'd5;
  localparam logic [3:0] AluSrl   = 4'd6;
  localparam logic [3:0] AluSra   = 4'd7;
  localparam logic [3:0] AluOr    = 4'd8;
  localparam logic [3:0] AluAnd   = 4'd9;
  localparam logic [3:0] AluPassB = 4'd10;

  localparam logic [2:0] EncR = 3'd0;
  localparam logic [2:0] EncI = 3'd1;
  localparam logic [2:0] EncS = 3'd2;
  localparam logic [2:0] EncB = 3'd3;
  localparam logic [2:0] EncU = 3'd4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [3:0]      alu_op;
    logic            alu_src;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            mem_to_reg;
    logic [1:0]      branch;
    logic [2:0]      encoding;
    logic            illegal;
  } bundle_t;

  // Shared funct3 -> ALU op mapping for the funct7=0 R-type and I-type forms.
  function automatic logic [3:0] base_op(input logic [2:0] f3);
    logic [3:0] op;
    case (f3)
      3'b000:  op = AluAdd;
      3'b001:  op = AluSll;
      3'b010:  op = AluSlt;
      3'b011:  op = AluSltu;
      3'b100:  op = AluXor;
      3'b101:  op = AluSrl;
      3'b110:  op = AluOr;
      default: op = AluAnd;
    endcase
    return op;
  endfunction

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // Signed casts sign-extend from bit 31 to XLEN.
  assign imm_i = XLEN'($signed(instr[31:20]));
  assign imm_s = XLEN'($signed({instr[31:25], instr[11:7]}));
  assign imm_b = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({instr[31:12], 12'b0}));

  bundle_t dec;
  logic    legal, is_shift, uses_rs1, uses_rs2;

  // Combinational decode of the incoming instruction into a full bundle.
  always_comb begin
    dec      = '0;
    dec.pc   = pc;
    dec.rs1  = instr[19:15];
    dec.rs2  = instr[24:20];
    dec.rd   = instr[11:7];
    legal    = 1'b0;
    is_shift = 1'b0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (opcode)
      OpcReg: begin
        dec.encoding  = EncR;
        dec.reg_write = 1'b1;
        uses_rs1      = 1'b1;
        uses_rs2      = 1'b1;
        is_shift      = (funct3 == 3'b001) || (funct3 == 3'b101);
        if (funct7 == 7'b0000000) begin
          legal      = 1'b1;
          dec.alu_op = base_op(funct3);
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          legal      = 1'b1;
          dec.alu_op = AluSub;
        end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
          legal      = 1'b1;
          dec.alu_op = AluSra;
        end
      end
      OpcImm: begin
        dec.encoding  = EncI;
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.imm       = imm_i;
        uses_rs1      = 1'b1;
        is_shift      = (funct3 == 3'b001) || (funct3 == 3'b101);
        case (funct3)
          3'b001: begin
            legal      = (funct7 == 7'b0000000);
            dec.alu_op = AluSll;
          end
          3'b101: begin
            if (funct7 == 7'b0000000) begin
              legal      = 1'b1;
              dec.alu_op = AluSrl;
            end else if (funct7 == 7'b0100000) begin
              legal      = 1'b1;
              dec.alu_op = AluSra;
            end
          end
          default: begin
            legal      = 1'b1;
            dec.alu_op = base_op(funct3);
          end
        endcase
      end
      OpcLoad: begin
        legal          = (funct3 == 3'b010);
        dec.encoding   = EncI;
        dec.alu_op     = AluAdd;
        dec.alu_src    = 1'b1;
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.reg_write  = 1'b1;
        dec.imm        = imm_i;
        uses_rs1       = 1'b1;
      end
      OpcStore: begin
        legal         = (funct3 == 3'b010);
        dec.encoding  = EncS;
        dec.alu_op    = AluAdd;
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
        dec.imm       = imm_s;
        uses_rs1      = 1'b1;
        uses_rs2      = 1'b1;
      end
      OpcBranch: begin
        legal        = (funct3 == 3'b000) || (funct3 == 3'b001);
        dec.encoding = EncB;
        dec.alu_op   = AluSub;
        dec.branch   = (funct3 == 3'b001) ? 2'd2 : 2'd1;
        dec.imm      = imm_b;
        uses_rs1     = 1'b1;
        uses_rs2     = 1'b1;
      end
      OpcLui: begin
        legal         = 1'b1;
        dec.encoding  = EncU;
        dec.alu_op    = AluPassB;
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.imm       = imm_u;
      end
      default: ;
    endcase
    // Illegal bundles keep pc and register fields but zero every control bit.
    if (!legal || (is_shift && !ENABLE_SHIFTS)) begin
      dec         = '0;
      dec.pc      = pc;
      dec.rs1     = instr[19:15];
      dec.rs2     = instr[24:20];
      dec.rd      = instr[11:7];
      dec.illegal = 1'b1;
      uses_rs1    = 1'b0;
      uses_rs2    = 1'b0;
    end
  end

  logic    valid_q, valid_d;
  bundle_t bundle_q, bundle_d;
  logic    hazard, stall;

  // Load-use hazard against the instruction currently in EX; x0 never stalls.
  always_comb begin
    hazard   = ex_mem_read && (ex_rd != 5'd0) &&
               ((uses_rs1 && (ex_rd == dec.rs1)) || (uses_rs2 && (ex_rd == dec.rs2)));
    stall    = HAZARD_DETECT && in_valid && hazard;
    in_ready = !rst && !flush && !stall && (!valid_q || out_ready);
  end

  // Next-state: flush kills, accept loads, drain bubbles, otherwise hold.
  always_comb begin
    valid_d  = valid_q;
    bundle_d = bundle_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (in_valid && in_ready) begin
      valid_d  = 1'b1;
      bundle_d = dec;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Output pipeline register with synchronous reset clearing every field.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      bundle_q <= '0;
    end else begin
      valid_q  <= valid_d;
      bundle_q <= bundle_d;
    end
  end

  assign out_valid      = valid_q;
  assign out_pc         = bundle_q.pc;
  assign out_rs1        = bundle_q.rs1;
  assign out_rs2        = bundle_q.rs2;
  assign out_rd         = bundle_q.rd;
  assign out_imm        = bundle_q.imm;
  assign out_alu_op     = bundle_q.alu_op;
  assign out_alu_src    = bundle_q.alu_src;
  assign out_reg_write  = bundle_q.reg_write;
  assign out_mem_read   = bundle_q.mem_read;
  assign out_mem_write  = bundle_q.mem_write;
  assign out_mem_to_reg = bundle_q.mem_to_reg;
  assign out_branch     = bundle_q.branch;
  assign out_encoding   = bundle_q.encoding;
  assign out_illegal    = bundle_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a decode vector table plus hand-written
// sequences for stall, backpressure, flush and reset.
module tb_decode_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        flush;
  logic        ex_mem_read;
  logic [4:0]  ex_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [31:0] out_imm;
  logic [3:0]  out_alu_op;
  logic        out_alu_src, out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg;
  logic [1:0]  out_branch;
  logic [2:0]  out_encoding;
  logic        out_illegal;

  // Second instance with shifts disabled; only its illegal flag is checked.
  logic        ns_in_ready, ns_out_valid;
  logic [31:0] ns_out_pc, ns_out_imm;
  logic [4:0]  ns_out_rs1, ns_out_rs2, ns_out_rd;
  logic [3:0]  ns_out_alu_op;
  logic        ns_out_alu_src, ns_out_reg_write, ns_out_mem_read, ns_out_mem_write;
  logic        ns_out_mem_to_reg, ns_out_illegal;
  logic [1:0]  ns_out_branch;
  logic [2:0]  ns_out_encoding;

  int errors = 0;
  int checks = 0;

  decode_stage #(.XLEN(32), .ENABLE_SHIFTS(1'b1), .HAZARD_DETECT(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr), .pc(pc),
    .flush(flush), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_rd(out_rd), .out_imm(out_imm), .out_alu_op(out_alu_op), .out_alu_src(out_alu_src),
    .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .out_mem_to_reg(out_mem_to_reg), .out_branch(out_branch),
    .out_encoding(out_encoding), .out_illegal(out_illegal)
  );

  decode_stage #(.XLEN(32), .ENABLE_SHIFTS(1'b0), .HAZARD_DETECT(1'b1)) dut_ns (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ns_in_ready), .instr(instr),
    .pc(pc), .flush(flush), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .out_valid(ns_out_valid), .out_ready(out_ready), .out_pc(ns_out_pc),
    .out_rs1(ns_out_rs1), .out_rs2(ns_out_rs2), .out_rd(ns_out_rd), .out_imm(ns_out_imm),
    .out_alu_op(ns_out_alu_op), .out_alu_src(ns_out_alu_src),
    .out_reg_write(ns_out_reg_write), .out_mem_read(ns_out_mem_read),
    .out_mem_write(ns_out_mem_write), .out_mem_to_reg(ns_out_mem_to_reg),
    .out_branch(ns_out_branch), .out_encoding(ns_out_encoding), .out_illegal(ns_out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        imm_chk;
    logic [31:0] imm;
    logic [3:0]  alu_op;
    logic        alu_src, rw, mr, mw, m2r;
    logic [1:0]  br;
    logic [2:0]  enc;
    logic        ill, ill_ns;
  } vec_t;

  localparam int NumVec = 13;
  vec_t vecs[NumVec];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [14:0] act_ctl();
    return {out_alu_op, out_alu_src, out_reg_write, out_mem_read, out_mem_write,
            out_mem_to_reg, out_branch, out_encoding, out_illegal};
  endfunction

  function automatic logic [14:0] vec_ctl(input vec_t v);
    return {v.alu_op, v.alu_src, v.rw, v.mr, v.mw, v.m2r, v.br, v.enc, v.ill};
  endfunction

  // ADD: op 0, reg_write, R encoding; SUB: op 1, reg_write, R encoding.
  localparam logic [14:0] CtlAdd = {4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0};
  localparam logic [14:0] CtlSub = {4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0};

  initial begin
    //             instr         imm?  imm           op  src rw mr mw m2r br enc ill ns
    vecs[0]  = '{32'h00500093, 1'b1, 32'h00000005, 4'd0, 1, 1, 0, 0, 0, 2'd0, 3'd1, 0, 0};
    vecs[1]  = '{32'h402081B3, 1'b0, 32'h00000000, 4'd1, 0, 1, 0, 0, 0, 2'd0, 3'd0, 0, 0};
    vecs[2]  = '{32'hFE20AE23, 1'b1, 32'hFFFFFFFC, 4'd0, 1, 0, 0, 1, 0, 2'd0, 3'd2, 0, 0};
    vecs[3]  = '{32'h00812283, 1'b1, 32'h00000008, 4'd0, 1, 1, 1, 0, 1, 2'd0, 3'd1, 0, 0};
    vecs[4]  = '{32'h00209863, 1'b1, 32'h00000010, 4'd1, 0, 0, 0, 0, 0, 2'd2, 3'd3, 0, 0};
    vecs[5]  = '{32'hFE000EE3, 1'b1, 32'hFFFFFFFC, 4'd1, 0, 0, 0, 0, 0, 2'd1, 3'd3, 0, 0};
    vecs[6]  = '{32'hABCDE3B7, 1'b1, 32'hABCDE000, 4'd10, 1, 1, 0, 0, 0, 2'd0, 3'd4, 0, 0};
    vecs[7]  = '{32'h4031D213, 1'b1, 32'h00000403, 4'd7, 1, 1, 0, 0, 0, 2'd0, 3'd1, 0, 1};
    vecs[8]  = '{32'h002091B3, 1'b0, 32'h00000000, 4'd2, 0, 1, 0, 0, 0, 2'd0, 3'd0, 0, 1};
    vecs[9]  = '{32'hFFFFFFFF, 1'b0, 32'h00000000, 4'd0, 0, 0, 0, 0, 0, 2'd0, 3'd0, 1, 1};
    vecs[10] = '{32'h022081B3, 1'b0, 32'h00000000, 4'd0, 0, 0, 0, 0, 0, 2'd0, 3'd0, 1, 1};
    vecs[11] = '{32'hFFF13093, 1'b1, 32'hFFFFFFFF, 4'd4, 1, 1, 0, 0, 0, 2'd0, 3'd1, 0, 0};
    vecs[12] = '{32'h007372B3, 1'b0, 32'h00000000, 4'd9, 0, 1, 0, 0, 0, 2'd0, 3'd0, 0, 0};

    rst = 1'b1; in_valid = 1'b0; instr = 32'h0; pc = 32'h0; flush = 1'b0;
    ex_mem_read = 1'b0; ex_rd = 5'd0; out_ready = 1'b1;

    // Reset state.
    step();
    step();
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_ctl", 64'(act_ctl()), 64'd0);
    check("rst_imm", 64'(out_imm), 64'd0);
    check("rst_pc", 64'(out_pc), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;

    // Decode table, back-to-back at one instruction per cycle.
    for (int i = 0; i < NumVec; i++) begin
      in_valid = 1'b1;
      instr    = vecs[i].instr;
      pc       = 32'h1000 + 32'(i * 4);
      #1;
      check($sformatf("v%0d_ready", i), 64'(in_ready), 64'd1);
      step();
      check($sformatf("v%0d_valid", i), 64'(out_valid), 64'd1);
      check($sformatf("v%0d_ctl", i), 64'(act_ctl()), 64'(vec_ctl(vecs[i])));
      check($sformatf("v%0d_regs", i), 64'({out_rs1, out_rs2, out_rd}),
            64'({vecs[i].instr[19:15], vecs[i].instr[24:20], vecs[i].instr[11:7]}));
      check($sformatf("v%0d_pc", i), 64'(out_pc), 64'(32'h1000 + 32'(i * 4)));
      check($sformatf("v%0d_ns_ill", i), 64'(ns_out_illegal), 64'(vecs[i].ill_ns));
      if (vecs[i].imm_chk)
        check($sformatf("v%0d_imm", i), 64'(out_imm), 64'(vecs[i].imm));
    end

    // Hazard terms, combinational, with an output bundle still valid.
    ex_mem_read = 1'b1;
    instr = 32'hABCDE3B7; ex_rd = 5'd27;  // LUI does not read rs1
    #1 check("lui_no_stall", 64'(in_ready), 64'd1);
    instr = 32'h002081B3; ex_rd = 5'd0;   // x0 never stalls
    #1 check("x0_no_stall", 64'(in_ready), 64'd1);
    ex_rd = 5'd2;                         // rs2 match
    #1 check("rs2_stall", 64'(in_ready), 64'd0);
    ex_rd = 5'd1; pc = 32'h100;           // rs1 match, held two cycles
    step();
    check("stall1_valid", 64'(out_valid), 64'd0);
    check("stall1_ready", 64'(in_ready), 64'd0);
    step();
    check("stall2_valid", 64'(out_valid), 64'd0);
    ex_mem_read = 1'b0;
    #1 check("unstall_ready", 64'(in_ready), 64'd1);
    step();
    check("unstall_valid", 64'(out_valid), 64'd1);
    check("unstall_pc", 64'(out_pc), 64'h100);
    check("unstall_ctl", 64'(act_ctl()), 64'(CtlAdd));

    // Backpressure: ADD bundle held, SUB waiting.
    out_ready = 1'b0; instr = 32'h402081B3; pc = 32'h104;
    for (int c = 0; c < 3; c++) begin
      #1 check($sformatf("bp%0d_ready", c), 64'(in_ready), 64'd0);
      step();
      check($sformatf("bp%0d_valid", c), 64'(out_valid), 64'd1);
      check($sformatf("bp%0d_pc", c), 64'(out_pc), 64'h100);
      check($sformatf("bp%0d_ctl", c), 64'(act_ctl()), 64'(CtlAdd));
    end
    out_ready = 1'b1;
    #1 check("bp_rel_ready", 64'(in_ready), 64'd1);
    step();
    check("bp_rel_pc", 64'(out_pc), 64'h104);
    check("bp_rel_ctl", 64'(act_ctl()), 64'(CtlSub));

    // Flush with in_valid: not consumed, then re-presented and accepted.
    instr = 32'h00500093; pc = 32'h108; flush = 1'b1;
    #1 check("flush_ready", 64'(in_ready), 64'd0);
    step();
    check("flush_valid", 64'(out_valid), 64'd0);
    flush = 1'b0;
    #1 check("reflush_ready", 64'(in_ready), 64'd1);
    step();
    check("reflush_valid", 64'(out_valid), 64'd1);
    check("reflush_pc", 64'(out_pc), 64'h108);

    // Flush during backpressure discards the held bundle.
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b1;
    step();
    check("flush_bp_valid", 64'(out_valid), 64'd0);
    flush = 1'b0; out_ready = 1'b1;

    // Reset mid-stream clears everything.
    in_valid = 1'b1; instr = 32'hABCDE3B7; pc = 32'h10C;
    step();
    check("mid_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    #1 check("mid_rst_ready", 64'(in_ready), 64'd0);
    step();
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_imm", 64'(out_imm), 64'd0);
    check("mid_rst_ctl", 64'(act_ctl()), 64'd0);
    rst = 1'b0; in_valid = 1'b0;
    step();
    check("post_rst_valid", 64'(out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
